// File: rtl/rojo_cmd_sequencer_if.sv
// Signal bundle between firmware-side GPIO registers and rojo_cmd_sequencer.
// master = register file / firmware side, slave = the sequencer.
interface rojo_cmd_sequencer_if #(
  parameter int unsigned DEPTH = 4
);
  logic                      cmd_valid;
  logic [7:0]                cmd_ctrl;
  logic [7:0]                cmd_count;
  logic                      cmd_ready;
  logic                      flush;
  logic                      upd_pulse;
  logic                      int_ack;
  logic [7:0]                bot_ctrl;
  logic                      busy;
  logic [$clog2(DEPTH):0]    fifo_level;
  logic                      seq_done;
  logic                      int_req;
  logic [7:0]                overrun_cnt;

  modport master (
    output cmd_valid, cmd_ctrl, cmd_count, flush, upd_pulse, int_ack,
    input  cmd_ready, bot_ctrl, busy, fifo_level, seq_done, int_req, overrun_cnt
  );

  modport slave (
    input  cmd_valid, cmd_ctrl, cmd_count, flush, upd_pulse, int_ack,
    output cmd_ready, bot_ctrl, busy, fifo_level, seq_done, int_req, overrun_cnt
  );
endinterface

// File: rtl/rojo_cmd_sequencer.sv
// Rojobot motion-command scheduler: FIFO of (ctrl, duration) pairs replayed per bot update.
// Optional overrun counter enabled by defining ROJO_SEQ_OVERRUN_CNT_EN.
module rojo_cmd_sequencer #(
  parameter int unsigned DEPTH     = 4,
  parameter logic [7:0]  STOP_CODE = 8'h00
) (
  input  logic                 HCLK,
  input  logic                 HRESETn,
  rojo_cmd_sequencer_if.slave  bus
);
  localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned LW = AW + 1;

  typedef enum logic [1:0] {IDLE, LOAD, RUN} state_t;

  state_t          r_state, w_state_nxt;
  logic [7:0]      r_mem_ctrl [DEPTH];
  logic [7:0]      r_mem_cnt  [DEPTH];
  logic [AW-1:0]   r_wptr, r_rptr;
  logic [LW-1:0]   r_level, w_level_nxt;
  logic            w_ready, w_push, w_pop;
  logic [7:0]      w_head_ctrl, w_head_cnt;
  logic [7:0]      r_bot_ctrl, w_ctrl_nxt;
  logic [7:0]      r_remaining, w_rem_nxt;
  logic            w_done_nxt, r_seq_done, r_busy, r_int_req;

  assign w_ready     = (r_level != LW'(DEPTH)) && !bus.flush;
  assign w_push      = bus.cmd_valid && w_ready;
  // LOAD is only entered with at least one entry, so the pop never underflows
  assign w_pop       = (r_state == LOAD) && !bus.flush;
  assign w_level_nxt = r_level + LW'(w_push) - LW'(w_pop);
  assign w_head_ctrl = r_mem_ctrl[r_rptr];
  assign w_head_cnt  = r_mem_cnt[r_rptr];

  always_ff @(posedge HCLK) begin
    if (w_push) begin
      r_mem_ctrl[r_wptr] <= bus.cmd_ctrl;
      r_mem_cnt[r_wptr]  <= bus.cmd_count;
    end
  end

  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_level <= '0;
    end else if (bus.flush) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_level <= '0;
    end else begin
      if (w_push) r_wptr <= r_wptr + AW'(1);
      if (w_pop)  r_rptr <= r_rptr + AW'(1);
      r_level <= w_level_nxt;
    end
  end

  // Emptiness decisions use the post-push/pop level so a push landing in
  // the same cycle keeps the sequence going instead of bouncing through IDLE.
  always_comb begin
    w_state_nxt = r_state;
    w_ctrl_nxt  = r_bot_ctrl;
    w_rem_nxt   = r_remaining;
    w_done_nxt  = 1'b0;
    unique case (r_state)
      IDLE: begin
        w_ctrl_nxt = STOP_CODE;
        if (w_level_nxt != '0) w_state_nxt = LOAD;
      end
      LOAD: begin
        if (w_head_cnt == 8'd0) begin
          if (w_level_nxt == '0) begin
            w_state_nxt = IDLE;
            w_ctrl_nxt  = STOP_CODE;
            w_done_nxt  = 1'b1;
          end
        end else begin
          w_state_nxt = RUN;
          w_ctrl_nxt  = w_head_ctrl;
          w_rem_nxt   = w_head_cnt;
        end
      end
      RUN: begin
        if (bus.upd_pulse) begin
          w_rem_nxt = r_remaining - 8'd1;
          if (r_remaining == 8'd1) begin
            if (w_level_nxt != '0) begin
              w_state_nxt = LOAD;
            end else begin
              w_state_nxt = IDLE;
              w_ctrl_nxt  = STOP_CODE;
              w_done_nxt  = 1'b1;
            end
          end
        end
      end
      default: w_state_nxt = IDLE;
    endcase
    if (bus.flush) begin
      w_state_nxt = IDLE;
      w_ctrl_nxt  = STOP_CODE;
      w_done_nxt  = 1'b0;
    end
  end

  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      r_state     <= IDLE;
      r_bot_ctrl  <= STOP_CODE;
      r_remaining <= '0;
      r_seq_done  <= 1'b0;
      r_busy      <= 1'b0;
    end else begin
      r_state     <= w_state_nxt;
      r_bot_ctrl  <= w_ctrl_nxt;
      r_remaining <= w_rem_nxt;
      r_seq_done  <= w_done_nxt;
      r_busy      <= (w_state_nxt != IDLE);
    end
  end

  // A pulse coinciding with an ack wins, so the new update is not lost.
  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn)           r_int_req <= 1'b0;
    else if (bus.upd_pulse) r_int_req <= 1'b1;
    else if (bus.int_ack)   r_int_req <= 1'b0;
  end

`ifdef ROJO_SEQ_OVERRUN_CNT_EN
  logic [7:0] r_overrun;

  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      r_overrun <= '0;
    end else if (bus.upd_pulse && r_int_req && !bus.int_ack) begin
      if (r_overrun != '1) r_overrun <= r_overrun + 8'd1;
    end else if (bus.int_ack && !bus.upd_pulse) begin
      r_overrun <= '0;
    end
  end

  assign bus.overrun_cnt = r_overrun;
`else
  assign bus.overrun_cnt = 8'h00;
`endif

  assign bus.cmd_ready  = w_ready;
  assign bus.bot_ctrl   = r_bot_ctrl;
  assign bus.busy       = r_busy;
  assign bus.fifo_level = r_level;
  assign bus.seq_done   = r_seq_done;
  assign bus.int_req    = r_int_req;
endmodule

// File: tb/tb_rojo_cmd_sequencer.sv
// Scoreboard bench for rojo_cmd_sequencer: bot_ctrl changes and seq_done pulses are
// checked against an expected-event queue; level/interrupt state is checked directly.
module tb_rojo_cmd_sequencer;
  localparam int unsigned DEPTH = 4;
`ifdef ROJO_SEQ_OVERRUN_CNT_EN
  localparam logic [7:0] EXP_OVR3   = 8'd3;
  localparam logic [7:0] EXP_OVRSAT = 8'hFF;
`else
  localparam logic [7:0] EXP_OVR3   = 8'h00;
  localparam logic [7:0] EXP_OVRSAT = 8'h00;
`endif

  logic HCLK = 1'b0;
  logic HRESETn = 1'b0;
  always #5 HCLK = ~HCLK;

  rojo_cmd_sequencer_if #(.DEPTH(DEPTH)) bus ();

  rojo_cmd_sequencer #(.DEPTH(DEPTH), .STOP_CODE(8'h00)) dut (
    .HCLK    (HCLK),
    .HRESETn (HRESETn),
    .bus     (bus)
  );

  typedef struct {
    bit         done;
    logic [7:0] ctrl;
  } ev_t;

  ev_t exp_q[$];
  int  errors = 0;
  int  checks = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic expect_ctrl(input logic [7:0] c);
    ev_t e;
    e.done = 1'b0;
    e.ctrl = c;
    exp_q.push_back(e);
  endtask

  task automatic expect_done();
    ev_t e;
    e.done = 1'b1;
    e.ctrl = 8'h00;
    exp_q.push_back(e);
  endtask

  task automatic observe(input bit done, input logic [7:0] c);
    ev_t e;
    if (exp_q.size() == 0) begin
      checks++;
      errors++;
      $display("FAIL unexpected_event: got done=%0b ctrl=%0h expected none at %0t", done, c, $time);
    end else begin
      e = exp_q.pop_front();
      check("event_kind", 32'(done), 32'(e.done));
      if (!e.done) check("event_ctrl", 32'(c), 32'(e.ctrl));
    end
  endtask

  // Monitor: every bot_ctrl change and every seq_done pulse is an output event.
  logic [7:0] prev_ctrl = 8'h00;
  initial begin
    forever begin
      @(negedge HCLK);
      if (!HRESETn) begin
        prev_ctrl = bus.bot_ctrl;
      end else begin
        if (bus.bot_ctrl !== prev_ctrl) observe(1'b0, bus.bot_ctrl);
        if (bus.seq_done === 1'b1) observe(1'b1, 8'h00);
        prev_ctrl = bus.bot_ctrl;
      end
    end
  end

  task automatic tick();
    @(posedge HCLK);
    #1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic push(input logic [7:0] c, input logic [7:0] n);
    bus.cmd_valid = 1'b1;
    bus.cmd_ctrl  = c;
    bus.cmd_count = n;
    tick();
    bus.cmd_valid = 1'b0;
  endtask

  task automatic pulse();
    bus.upd_pulse = 1'b1;
    tick();
    bus.upd_pulse = 1'b0;
    idle(3);
  endtask

  initial begin
    bus.cmd_valid = 1'b0;
    bus.cmd_ctrl  = 8'h00;
    bus.cmd_count = 8'h00;
    bus.flush     = 1'b0;
    bus.upd_pulse = 1'b0;
    bus.int_ack   = 1'b1;
    idle(3);
    HRESETn = 1'b1;
    tick();

    check("rst_bot_ctrl",  32'(bus.bot_ctrl), 32'h00);
    check("rst_level",     32'(bus.fifo_level), 32'd0);
    check("rst_cmd_ready", 32'(bus.cmd_ready), 32'd1);
    check("rst_busy",      32'(bus.busy), 32'd0);
    check("rst_seq_done",  32'(bus.seq_done), 32'd0);
    check("rst_int_req",   32'(bus.int_req), 32'd0);
    check("rst_overrun",   32'(bus.overrun_cnt), 32'd0);

    // Sequencing: 0x33 x3 pulses, then 0x44 x1, then stop + done
    expect_ctrl(8'h33);
    expect_ctrl(8'h44);
    expect_ctrl(8'h00);
    expect_done();
    push(8'h33, 8'd3);
    check("seq_busy_load", 32'(bus.busy), 32'd1);
    push(8'h44, 8'd1);
    check("seq_first_byte_2cyc", 32'(bus.bot_ctrl), 32'h33);
    check("seq_level_one",       32'(bus.fifo_level), 32'd1);
    pulse();
    pulse();
    check("seq_hold_after_2", 32'(bus.bot_ctrl), 32'h33);
    pulse();
    check("seq_second_byte", 32'(bus.bot_ctrl), 32'h44);
    check("seq_level_empty", 32'(bus.fifo_level), 32'd0);
    pulse();
    check("seq_stop",      32'(bus.bot_ctrl), 32'h00);
    check("seq_idle",      32'(bus.busy), 32'd0);
    check("seq_done_low",  32'(bus.seq_done), 32'd0);

    // Fill the FIFO, try a push while full
    expect_ctrl(8'h11);
    expect_ctrl(8'h22);
    for (int i = 0; i < 6; i++) begin
      if (i == 5) begin
        check("full_ready_low", 32'(bus.cmd_ready), 32'd0);
        check("full_level",     32'(bus.fifo_level), 32'd4);
      end
      bus.cmd_valid = 1'b1;
      bus.cmd_ctrl  = 8'(8'h11 * (i + 1));
      bus.cmd_count = 8'd1;
      tick();
    end
    bus.cmd_valid = 1'b0;
    check("full_push_ignored", 32'(bus.fifo_level), 32'd4);
    pulse();
    check("run_three_queued", 32'(bus.fifo_level), 32'd3);

    // Flush in RUN with a simultaneous push
    expect_ctrl(8'h00);
    bus.flush     = 1'b1;
    bus.cmd_valid = 1'b1;
    bus.cmd_ctrl  = 8'h77;
    bus.cmd_count = 8'd1;
    tick();
    bus.flush     = 1'b0;
    bus.cmd_valid = 1'b0;
    check("flush_idle",     32'(bus.busy), 32'd0);
    check("flush_level",    32'(bus.fifo_level), 32'd0);
    check("flush_bot",      32'(bus.bot_ctrl), 32'h00);
    check("flush_no_done",  32'(bus.seq_done), 32'd0);
    idle(3);
    check("flush_push_dropped", 32'(bus.fifo_level), 32'd0);
    check("flush_stays_idle",   32'(bus.busy), 32'd0);

    // Lone zero-count entry: skipped, sequence completes at once
    expect_done();
    push(8'h5A, 8'd0);
    idle(3);
    check("skip_only_bot", 32'(bus.bot_ctrl), 32'h00);

    // Zero-count entry followed by a real one
    expect_ctrl(8'h66);
    expect_ctrl(8'h00);
    expect_done();
    push(8'h55, 8'd0);
    push(8'h66, 8'd2);
    tick();
    check("skip_bot_66", 32'(bus.bot_ctrl), 32'h66);
    pulse();
    check("skip_hold_66", 32'(bus.bot_ctrl), 32'h66);
    pulse();
    check("skip_stop", 32'(bus.bot_ctrl), 32'h00);

    // Reset in the middle of RUN with an interrupt pending
    bus.int_ack = 1'b0;
    expect_ctrl(8'h99);
    push(8'h99, 8'd5);
    idle(2);
    pulse();
    check("pre_rst_int_req", 32'(bus.int_req), 32'd1);
    #2 HRESETn = 1'b0;
    #1;
    check("midrst_bot",     32'(bus.bot_ctrl), 32'h00);
    check("midrst_level",   32'(bus.fifo_level), 32'd0);
    check("midrst_busy",    32'(bus.busy), 32'd0);
    check("midrst_int_req", 32'(bus.int_req), 32'd0);
    idle(2);
    HRESETn = 1'b1;
    idle(2);

    // Interrupt handshake and overrun counting
    bus.upd_pulse = 1'b1;
    tick();
    bus.upd_pulse = 1'b0;
    check("int_rise", 32'(bus.int_req), 32'd1);
    bus.upd_pulse = 1'b1;
    bus.int_ack   = 1'b1;
    tick();
    bus.upd_pulse = 1'b0;
    bus.int_ack   = 1'b0;
    check("int_pulse_ack_held", 32'(bus.int_req), 32'd1);
    check("int_pulse_ack_ovr",  32'(bus.overrun_cnt), 32'd0);
    for (int i = 0; i < 3; i++) begin
      bus.upd_pulse = 1'b1;
      tick();
      bus.upd_pulse = 1'b0;
      tick();
    end
    check("int_req_held", 32'(bus.int_req), 32'd1);
    check("overrun_3",    32'(bus.overrun_cnt), 32'(EXP_OVR3));
    bus.int_ack = 1'b1;
    tick();
    bus.int_ack = 1'b0;
    check("ack_clear_req", 32'(bus.int_req), 32'd0);
    check("ack_clear_ovr", 32'(bus.overrun_cnt), 32'd0);

    // Saturation: 300 back-to-back unacked pulses
    bus.upd_pulse = 1'b1;
    idle(300);
    bus.upd_pulse = 1'b0;
    check("ovr_saturate", 32'(bus.overrun_cnt), 32'(EXP_OVRSAT));
    bus.int_ack = 1'b1;
    tick();
    bus.int_ack = 1'b0;
    check("sat_ack_ovr", 32'(bus.overrun_cnt), 32'd0);
    check("sat_ack_req", 32'(bus.int_req), 32'd0);

    idle(2);
    check("scoreboard_drained", 32'(exp_q.size()), 32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/rojo_cmd_sequencer.md
# rojo_cmd_sequencer

Hardware motion-command scheduler for the Rojobot control byte. Firmware pushes (control byte, duration) pairs into a small FIFO. The block drives each control byte onto the bot for the requested number of bot update periods, then advances to the next pair. It sits between the AHB GPIO register file and the Rojobot, and also owns the update-interrupt request/acknowledge handshake.

## Interface
Parameters:
- DEPTH, 4, command FIFO depth; power of two, 2..16
- STOP_CODE, 8'h00, control byte driven when idle or flushed

Ports:
- HCLK  in  1  system clock
- HRESETn  in  1  reset; asynchronous, active-low
- cmd_valid  in  1  push request
- cmd_ctrl  in  8  control byte to drive
- cmd_count  in  8  duration, in bot update pulses
- cmd_ready  out  1  FIFO not full and flush low
- flush  in  1  abort: empty the FIFO and stop the bot
- upd_pulse  in  1  one-HCLK pulse per bot update, already synchronized to HCLK
- int_ack  in  1  firmware interrupt acknowledge, level
- bot_ctrl  out  8  registered control byte to the Rojobot
- busy  out  1  FSM not in IDLE
- fifo_level  out  $clog2(DEPTH)+1  entries held
- seq_done  out  1  one-cycle pulse when the last queued command completes
- int_req  out  1  update interrupt request
- overrun_cnt  out  8  count of missed interrupts (only with the macro, see Configuration)

## Operation
- Reset values:
  - bot_ctrl = STOP_CODE
  - FIFO empty; fifo_level = 0; cmd_ready = 1
  - busy, seq_done, int_req = 0; overrun_cnt = 0
  - FSM = IDLE
- FIFO:
  - Push when cmd_valid & cmd_ready.
  - Pop only in LOAD.
  - A simultaneous push and pop leaves the level unchanged.
  - A push while full is impossible, because cmd_ready is low.
- FSM states: IDLE, LOAD, RUN.
  - IDLE: if the FIFO is non-empty, go to LOAD. Otherwise hold; bot_ctrl = STOP_CODE.
  - LOAD: pop the head entry.
    - count == 0: the entry is skipped and bot_ctrl is unchanged. Go to LOAD again if the FIFO (after the pop) is non-empty; otherwise go to IDLE with bot_ctrl = STOP_CODE and pulse seq_done.
    - count != 0: bot_ctrl <= ctrl, remaining <= count, go to RUN.
  - RUN: each upd_pulse decrements remaining. A pulse that takes remaining 1 -> 0 ends the command:
    - FIFO non-empty: go to LOAD, and bot_ctrl keeps its old value until LOAD.
    - FIFO empty: go to IDLE, bot_ctrl <= STOP_CODE, and seq_done pulses in the same cycle.
  - upd_pulse in IDLE or LOAD does not affect sequencing.
- flush:
  - Highest priority, in any state: next cycle the FSM is IDLE, the FIFO is empty, bot_ctrl = STOP_CODE, and seq_done stays 0.
  - A push in the same cycle as flush is dropped.
  - Interrupt logic is unaffected.
- Interrupt:
  - upd_pulse sets int_req; int_ack (sampled high) clears it.
  - Simultaneous pulse and ack: int_req stays 1, and this is not an overrun.
  - This logic is independent of the FSM state.

## Timing
- Push into an empty FIFO with the FSM in IDLE:
  - cycle 0: push accepted
  - cycle 1: LOAD
  - cycle 2: bot_ctrl shows the new byte; FSM in RUN
- Command with count N: bot_ctrl holds the byte for exactly N upd_pulses. The command ends in the cycle after the Nth pulse.
- Back-to-back commands: one HCLK cycle in LOAD between RUN phases. A pulse arriving in that LOAD cycle is not counted; firmware-visible pulse spacing is far larger than one cycle.
- int_req rises one cycle after upd_pulse and falls one cycle after int_ack.
- All outputs are registered except cmd_ready, which is combinational from the FIFO level and flush.

## Configuration
- Macro: ROJO_SEQ_OVERRUN_CNT_EN
- Defined:
  - overrun_cnt increments when upd_pulse arrives while int_req = 1 and int_ack = 0.
  - It saturates at 8'hFF.
  - It clears on reset, and on int_ack when upd_pulse is low.
- Undefined: the overrun_cnt port is still present but is tied to 8'h00, and no counter logic is built.

## Test plan
- Reset mid-RUN: after reset, bot_ctrl = 8'h00, fifo_level = 0, busy = 0, int_req = 0.
- Sequencing:
  - Stimulus: push (8'h33, 3), then (8'h44, 1).
  - Required: 8'h33 visible 2 cycles after the push; it holds for 3 pulses; then 8'h44 for 1 pulse; then 8'h00 with a single seq_done pulse.
- Full and skip:
  - Stimulus: push 4 entries so that cmd_ready drops, then a 5th cmd_valid; separately push (8'h55, 0) then (8'h66, 2).
  - Required: the 5th push is ignored and fifo_level stays 4. 8'h55 never appears on bot_ctrl; 8'h66 is driven for 2 pulses.
- Flush in RUN with 3 entries queued, and a push in the same cycle:
  - Required: the next cycle shows IDLE, fifo_level = 0, bot_ctrl = 8'h00, and no seq_done.
- Interrupt:
  - Stimulus: a pulse, then a pulse with int_ack in the same cycle, then 3 pulses with no ack (macro defined).
  - Required: int_req stays 1 throughout and overrun_cnt = 3. With the macro undefined, overrun_cnt = 0.
- Saturation: 300 unacked pulses -> overrun_cnt = 8'hFF; then int_ack -> overrun_cnt = 0 and int_req = 0.
